// File: rtl/ttt_turn_arbiter.sv
// Turn arbiter for a two-player tic-tac-toe engine: grants moves, checks cell
// legality, enforces a per-turn timeout and tracks game completion.
//   state   | meaning
//   S_IDLE  | no game yet, waiting for start
//   S_TURN  | cur_player may submit a move, timeout running
//   S_ISSUE | latched move driven to the engine (first cycle)
//   S_CHECK | engine result sampled, decide next turn / end of game
//   S_DONE  | game finished, result held until the next start
module ttt_turn_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p0_valid,
    input  logic       p1_valid,
    input  logic [1:0] p0_x,
    input  logic [1:0] p0_y,
    input  logic [1:0] p1_x,
    input  logic [1:0] p1_y,
    output logic       p0_ready,
    output logic       p1_ready,
    output logic       move_ack,
    output logic       move_reject,
    output logic       forfeit,
    output logic       eng_enable,
    output logic [1:0] eng_player,
    output logic [1:0] eng_x,
    output logic [1:0] eng_y,
    input  logic [1:0] eng_winner,
    input  logic       eng_stop_game,
    output logic       cur_player,
    output logic       game_over,
    output logic [1:0] result,
    output logic [3:0] move_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_ISSUE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [8:0]  r_board;
    logic [15:0] r_timer;
    logic        r_cur;
    logic        r_first;
    logic        r_move_ack;
    logic        r_move_reject;
    logic        r_forfeit;
    logic        r_eng_en;
    logic [1:0]  r_eng_player;
    logic [1:0]  r_eng_x;
    logic [1:0]  r_eng_y;
    logic        r_game_over;
    logic [1:0]  r_result;
    logic [3:0]  r_move_count;

    logic       w_p0_ready;
    logic       w_p1_ready;
    logic       w_hs;
    logic [1:0] w_req_x;
    logic [1:0] w_req_y;
    logic       w_in_range;
    logic [3:0] w_idx;
    logic [8:0] w_cell;
    logic       w_legal;
    logic       w_timeout;

    // Grant is combinational so a valid is accepted in the cycle it appears.
    assign w_p0_ready = (r_state == S_TURN) && !r_cur && p0_valid;
    assign w_p1_ready = (r_state == S_TURN) &&  r_cur && p1_valid;
    assign w_hs       = w_p0_ready || w_p1_ready;
    assign w_req_x    = r_cur ? p1_x : p0_x;
    assign w_req_y    = r_cur ? p1_y : p0_y;
    assign w_in_range = (w_req_x != 2'd3) && (w_req_y != 2'd3);
    assign w_idx      = ({2'b00, w_req_x} << 1) + {2'b00, w_req_x} + {2'b00, w_req_y};
    assign w_cell     = 9'd1 << w_idx;
    assign w_legal    = w_hs && w_in_range && ((r_board & w_cell) == 9'd0);
    assign w_timeout  = (r_timer == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_board       <= '0;
            r_timer       <= '0;
            r_cur         <= 1'b0;
            r_first       <= 1'b0;
            r_move_ack    <= 1'b0;
            r_move_reject <= 1'b0;
            r_forfeit     <= 1'b0;
            r_eng_en      <= 1'b0;
            r_eng_player  <= 2'd0;
            r_eng_x       <= 2'd0;
            r_eng_y       <= 2'd0;
            r_game_over   <= 1'b0;
            r_result      <= 2'd2;
            r_move_count  <= 4'd0;
        end else begin
            r_move_ack    <= 1'b0;
            r_move_reject <= 1'b0;
            r_forfeit     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_TURN;
                        r_board      <= '0;
                        r_timer      <= '0;
                        r_move_count <= 4'd0;
                        r_game_over  <= 1'b0;
                        r_result     <= 2'd2;
                        r_cur        <= r_first;
                    end
                end
                S_TURN: begin
                    // A legal move in the timeout cycle still counts.
                    if (w_legal) begin
                        r_state      <= S_ISSUE;
                        r_board      <= r_board | w_cell;
                        r_move_count <= r_move_count + 4'd1;
                        r_move_ack   <= 1'b1;
                        r_eng_en     <= 1'b1;
                        r_eng_player <= {1'b0, r_cur};
                        r_eng_x      <= w_req_x;
                        r_eng_y      <= w_req_y;
                    end else begin
                        if (w_hs) begin
                            r_move_reject <= 1'b1;
                        end
                        if (w_timeout) begin
                            r_forfeit <= 1'b1;
                            r_cur     <= ~r_cur;
                            r_timer   <= '0;
                        end else begin
                            r_timer <= r_timer + 16'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_eng_en <= 1'b0;
                    if (eng_stop_game) begin
                        r_state     <= S_DONE;
                        r_result    <= eng_winner;
                        r_game_over <= 1'b1;
                    end else if (r_move_count == 4'd9) begin
                        r_state     <= S_DONE;
                        r_result    <= 2'd3;
                        r_game_over <= 1'b1;
                    end else begin
                        r_state <= S_TURN;
                        r_cur   <= ~r_cur;
                        r_timer <= '0;
                    end
                end
                S_DONE: begin
                    // Openers alternate from one game to the next.
                    if (start) begin
                        r_state      <= S_TURN;
                        r_board      <= '0;
                        r_timer      <= '0;
                        r_move_count <= 4'd0;
                        r_game_over  <= 1'b0;
                        r_result     <= 2'd2;
                        r_first      <= ~r_first;
                        r_cur        <= ~r_first;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign p0_ready    = w_p0_ready;
    assign p1_ready    = w_p1_ready;
    assign move_ack    = r_move_ack;
    assign move_reject = r_move_reject;
    assign forfeit     = r_forfeit;
    assign eng_enable  = r_eng_en;
    assign eng_player  = r_eng_player;
    assign eng_x       = r_eng_x;
    assign eng_y       = r_eng_y;
    assign cur_player  = r_cur;
    assign game_over   = r_game_over;
    assign result      = r_result;
    assign move_count  = r_move_count;

endmodule

// File: tb/tb_ttt_turn_arbiter.sv
// Directed bench for ttt_turn_arbiter: reset, row win, turn/occupancy rules,
// timeout forfeits, draw with alternating opener, reset during CHECK.
module tb_ttt_turn_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       p0_valid, p1_valid;
    logic [1:0] p0_x, p0_y, p1_x, p1_y;
    logic       p0_ready, p1_ready;
    logic       move_ack, move_reject, forfeit;
    logic       eng_enable;
    logic [1:0] eng_player, eng_x, eng_y;
    logic [1:0] eng_winner;
    logic       eng_stop_game;
    logic       cur_player, game_over;
    logic [1:0] result;
    logic [3:0] move_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ttt_turn_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .p0_valid(p0_valid), .p1_valid(p1_valid),
        .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y),
        .p0_ready(p0_ready), .p1_ready(p1_ready),
        .move_ack(move_ack), .move_reject(move_reject), .forfeit(forfeit),
        .eng_enable(eng_enable), .eng_player(eng_player), .eng_x(eng_x), .eng_y(eng_y),
        .eng_winner(eng_winner), .eng_stop_game(eng_stop_game),
        .cur_player(cur_player), .game_over(game_over), .result(result),
        .move_count(move_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        start = 0; p0_valid = 0; p1_valid = 0;
        p0_x = 0; p0_y = 0; p1_x = 0; p1_y = 0;
        eng_winner = 0; eng_stop_game = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic start_game;
        start = 1;
        tick();
        start = 0;
    endtask

    // Drives one move from TURN through ISSUE and CHECK; returns observations only.
    task automatic do_move(input logic p, input logic [1:0] x, input logic [1:0] y,
                           input logic stop, input logic [1:0] win,
                           output logic rdy, output logic ack, output logic en1, output logic en2);
        if (p) begin p1_valid = 1; p1_x = x; p1_y = y; end
        else   begin p0_valid = 1; p0_x = x; p0_y = y; end
        #1 rdy = p ? p1_ready : p0_ready;
        tick();
        p0_valid = 0; p1_valid = 0;
        ack = move_ack; en1 = eng_enable;
        eng_stop_game = stop; eng_winner = win;
        tick();
        en2 = eng_enable;
        tick();
        eng_stop_game = 0; eng_winner = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1; start = 1; p0_valid = 1; eng_stop_game = 1; eng_winner = 1;
        tick();
        tick();
        checks++; if (p0_ready !== 1'b0) begin errors++; $display("FAIL reset_p0_ready: got %0b want 0", p0_ready); end
        checks++; if (move_ack !== 1'b0 || move_reject !== 1'b0 || forfeit !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %0b%0b%0b want 000", move_ack, move_reject, forfeit); end
        checks++; if (eng_enable !== 1'b0) begin errors++; $display("FAIL reset_eng_enable: got %0b want 0", eng_enable); end
        checks++; if (eng_player !== 2'd0 || eng_x !== 2'd0 || eng_y !== 2'd0) begin errors++; $display("FAIL reset_eng_bus: got p=%0d x=%0d y=%0d want 0 0 0", eng_player, eng_x, eng_y); end
        checks++; if (cur_player !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL reset_cur_over: got %0b %0b want 0 0", cur_player, game_over); end
        checks++; if (result !== 2'd2) begin errors++; $display("FAIL reset_result: got %0d want 2", result); end
        checks++; if (move_count !== 4'd0) begin errors++; $display("FAIL reset_move_count: got %0d want 0", move_count); end
        reset = 0;
        clear_inputs();
    endtask

    task automatic test_row_win;
        logic       ps [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0] xs [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        logic [1:0] ys [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        logic rdy, ack, en1, en2;
        int acks = 0;
        do_reset();
        start_game();
        checks++; if (eng_enable !== 1'b0) begin errors++; $display("FAIL row_en_before: got %0b want 0", eng_enable); end
        for (int i = 0; i < 5; i++) begin
            do_move(ps[i], xs[i], ys[i], (i == 4), 2'd0, rdy, ack, en1, en2);
            if (ack === 1'b1) acks++;
            if (i == 0) begin
                checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL row_grant: got %0b want 1", rdy); end
                checks++; if (en1 !== 1'b1 || en2 !== 1'b1) begin errors++; $display("FAIL row_eng_window: got %0b%0b want 11", en1, en2); end
                checks++; if (eng_enable !== 1'b0 || cur_player !== 1'b1) begin errors++; $display("FAIL row_back_to_turn: got en=%0b cur=%0b want 0 1", eng_enable, cur_player); end
                start = 1;
                tick();
                start = 0;
                checks++; if (move_count !== 4'd1 || cur_player !== 1'b1) begin errors++; $display("FAIL row_start_ignored: got cnt=%0d cur=%0b want 1 1", move_count, cur_player); end
            end
        end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL row_game_over: got %0b want 1", game_over); end
        checks++; if (result !== 2'd0) begin errors++; $display("FAIL row_result: got %0d want 0", result); end
        checks++; if (move_count !== 4'd5) begin errors++; $display("FAIL row_move_count: got %0d want 5", move_count); end
        checks++; if (acks != 5) begin errors++; $display("FAIL row_acks: got %0d want 5", acks); end
        checks++; if (eng_enable !== 1'b0 || eng_x !== 2'd0 || eng_y !== 2'd2 || eng_player !== 2'd0) begin errors++; $display("FAIL row_eng_hold: got en=%0b x=%0d y=%0d p=%0d want 0 0 2 0", eng_enable, eng_x, eng_y, eng_player); end
        p0_valid = 1;
        #1;
        checks++; if (p0_ready !== 1'b0) begin errors++; $display("FAIL row_done_ready: got %0b want 0", p0_ready); end
        p0_valid = 0;
    endtask

    task automatic test_turn_occupancy;
        logic rdy, ack, en1, en2;
        do_reset();
        start_game();
        p1_valid = 1; p1_x = 0; p1_y = 1;
        #1;
        checks++; if (p1_ready !== 1'b0) begin errors++; $display("FAIL occ_p1_not_turn: got %0b want 0", p1_ready); end
        do_move(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, rdy, ack, en1, en2);
        checks++; if (ack !== 1'b1 || eng_player !== 2'd0) begin errors++; $display("FAIL occ_p0_move: got ack=%0b p=%0d want 1 0", ack, eng_player); end
        checks++; if (cur_player !== 1'b1) begin errors++; $display("FAIL occ_cur_after: got %0b want 1", cur_player); end
        p1_valid = 1; p1_x = 0; p1_y = 0;
        #1;
        checks++; if (p1_ready !== 1'b1) begin errors++; $display("FAIL occ_p1_grant: got %0b want 1", p1_ready); end
        tick();
        p1_valid = 0;
        checks++; if (move_reject !== 1'b1 || move_ack !== 1'b0) begin errors++; $display("FAIL occ_reject: got rej=%0b ack=%0b want 1 0", move_reject, move_ack); end
        checks++; if (cur_player !== 1'b1 || move_count !== 4'd1 || dut.r_board !== 9'h001) begin errors++; $display("FAIL occ_unchanged: got cur=%0b cnt=%0d board=%03h want 1 1 001", cur_player, move_count, dut.r_board); end
        do_move(1'b1, 2'd1, 2'd1, 1'b0, 2'd0, rdy, ack, en1, en2);
        checks++; if (ack !== 1'b1 || eng_player !== 2'd1 || dut.r_board !== 9'h011) begin errors++; $display("FAIL occ_p1_legal: got ack=%0b p=%0d board=%03h want 1 1 011", ack, eng_player, dut.r_board); end
        p0_valid = 1; p0_x = 3; p0_y = 0;
        tick();
        p0_valid = 0;
        checks++; if (move_reject !== 1'b1 || move_count !== 4'd2) begin errors++; $display("FAIL occ_x3_reject: got rej=%0b cnt=%0d want 1 2", move_reject, move_count); end
    endtask

    task automatic test_timeout;
        do_reset();
        start_game();
        tick(); tick(); tick();
        checks++; if (forfeit !== 1'b0 || cur_player !== 1'b0) begin errors++; $display("FAIL to_early: got ff=%0b cur=%0b want 0 0", forfeit, cur_player); end
        tick();
        checks++; if (forfeit !== 1'b1 || cur_player !== 1'b1) begin errors++; $display("FAIL to_forfeit0: got ff=%0b cur=%0b want 1 1", forfeit, cur_player); end
        tick();
        checks++; if (forfeit !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %0b want 0", forfeit); end
        p1_valid = 1; p1_x = 3; p1_y = 3;
        tick();
        p1_valid = 0;
        checks++; if (move_reject !== 1'b1) begin errors++; $display("FAIL to_mid_reject: got %0b want 1", move_reject); end
        tick();
        checks++; if (forfeit !== 1'b0 || cur_player !== 1'b1) begin errors++; $display("FAIL to_not_yet: got ff=%0b cur=%0b want 0 1", forfeit, cur_player); end
        tick();
        checks++; if (forfeit !== 1'b1 || cur_player !== 1'b0) begin errors++; $display("FAIL to_forfeit1: got ff=%0b cur=%0b want 1 0", forfeit, cur_player); end
    endtask

    task automatic test_draw;
        logic [1:0] xs [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
        logic [1:0] ys [9] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2};
        logic rdy, ack, en1, en2;
        int bad_turns = 0;
        do_reset();
        start_game();
        for (int i = 0; i < 9; i++) begin
            do_move(logic'(i % 2), xs[i], ys[i], 1'b0, 2'd0, rdy, ack, en1, en2);
            if (i < 8 && cur_player !== logic'((i + 1) % 2)) bad_turns++;
        end
        checks++; if (bad_turns != 0) begin errors++; $display("FAIL draw_alternation: got %0d bad turns want 0", bad_turns); end
        checks++; if (game_over !== 1'b1 || result !== 2'd3) begin errors++; $display("FAIL draw_result: got over=%0b res=%0d want 1 3", game_over, result); end
        checks++; if (move_count !== 4'd9) begin errors++; $display("FAIL draw_move_count: got %0d want 9", move_count); end
        start_game();
        checks++; if (cur_player !== 1'b1 || game_over !== 1'b0 || move_count !== 4'd0) begin errors++; $display("FAIL draw_restart: got cur=%0b over=%0b cnt=%0d want 1 0 0", cur_player, game_over, move_count); end
        p1_valid = 1; p1_x = 1; p1_y = 1;
        #1;
        checks++; if (p1_ready !== 1'b1) begin errors++; $display("FAIL draw_p1_opens: got %0b want 1", p1_ready); end
        p1_valid = 0;
    endtask

    task automatic test_reset_mid_check;
        do_reset();
        start_game();
        p0_valid = 1; p0_x = 1; p0_y = 1;
        tick();
        p0_valid = 0;
        tick();
        checks++; if (eng_enable !== 1'b1 || dut.r_board !== 9'h010) begin errors++; $display("FAIL rmc_in_check: got en=%0b board=%03h want 1 010", eng_enable, dut.r_board); end
        reset = 1; eng_stop_game = 1; eng_winner = 2'd1;
        tick();
        checks++; if (eng_enable !== 1'b0 || result !== 2'd2 || game_over !== 1'b0) begin errors++; $display("FAIL rmc_outputs: got en=%0b res=%0d over=%0b want 0 2 0", eng_enable, result, game_over); end
        checks++; if (dut.r_board !== 9'h000 || move_count !== 4'd0) begin errors++; $display("FAIL rmc_cleared: got board=%03h cnt=%0d want 000 0", dut.r_board, move_count); end
        start = 1;
        tick();
        reset = 0; start = 0; eng_stop_game = 0; eng_winner = 0;
        p0_valid = 1;
        #1;
        checks++; if (p0_ready !== 1'b0) begin errors++; $display("FAIL rmc_start_with_reset: got ready=%0b want 0", p0_ready); end
        p0_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_row_win();
        test_turn_occupancy();
        test_timeout();
        test_draw();
        test_reset_mid_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ttt_turn_arbiter.md
TTT_TURN_ARBITER -- requirements
Module: ttt_turn_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning cycles a player may stay in TURN before forfeiting the turn (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse to begin a game (honoured only in IDLE or DONE).
REQ-005 SHALL have ports p0_valid, p1_valid  input  1 each  player move request.
REQ-006 SHALL have ports p0_x, p0_y, p1_x, p1_y  input  2 each  requested cell, row x, column y, each 0..2.
REQ-007 SHALL have ports p0_ready, p1_ready  output  1 each  handshake; a request is consumed on valid&ready.
REQ-008 SHALL have ports move_ack, move_reject, forfeit  output  1 each  one-cycle status pulses.
REQ-009 SHALL have ports eng_enable  output 1; eng_player  output 2; eng_x, eng_y  output 2 each  move drive to the game engine.
REQ-010 SHALL have ports eng_winner  input 2 and eng_stop_game  input 1  engine result (0/1 = player, 3 = draw).
REQ-011 SHALL have ports cur_player  output 1; game_over  output 1; result  output 2; move_count  output 4.

Function
REQ-012 SHALL implement states IDLE, TURN, ISSUE, CHECK, DONE.
REQ-013 IDLE: start -> TURN; board bitmap (9 bits, index 3*x+y) cleared, move_count=0, cur_player=first_player.
REQ-014 TURN: only cur_player's ready may be high; other player's valid ignored, ready low.
REQ-015 TURN: ready of cur_player SHALL equal its valid (same-cycle grant); on handshake, coordinate x=3 or y=3 or occupied cell -> move_reject pulse next cycle, stay TURN.
REQ-016 TURN: legal handshake -> latch x,y, set bitmap bit, move_count+1, move_ack pulse next cycle, go ISSUE.
REQ-017 TURN timeout counter SHALL clear on entry to TURN, increment each TURN cycle without legal handshake; rejects do not clear it.
REQ-018 Counter reaching TIMEOUT_CYCLES-1 without legal handshake -> forfeit pulse, cur_player toggles, counter clears, stay TURN; a legal handshake in that same cycle wins over timeout.
REQ-019 ISSUE (1 cycle) and CHECK (1 cycle): eng_enable=1, eng_player={1'b0,cur_player}, eng_x/eng_y = latched move; eng_enable=0 in all other states, eng_x/eng_y/eng_player hold last value.
REQ-020 End of CHECK: eng_stop_game=1 -> DONE, result=eng_winner; else move_count=9 -> DONE, result=3; else cur_player toggles, -> TURN.
REQ-021 eng_stop_game/eng_winner SHALL be ignored outside CHECK.
REQ-022 DONE: game_over=1, result held, all ready low; start -> same as IDLE start, with first_player toggled (alternating openers).
REQ-023 start in TURN/ISSUE/CHECK SHALL be ignored.
REQ-024 Latency: legal request handshake to eng_enable rising = 1 cycle; handshake to next TURN = 3 cycles.

Reset
REQ-025 reset SHALL win over every other input in the same cycle and apply in any state, including mid-ISSUE/CHECK.
REQ-026 After reset: state IDLE, all ready/pulses/eng_enable=0, eng_player=0, eng_x=eng_y=0, cur_player=0, first_player=0, game_over=0, result=2, move_count=0, bitmap=0, timeout counter=0.

Verification
REQ-027 Row win: start, moves P0(0,0) P1(1,0) P0(0,1) P1(1,1) P0(0,2), engine model returns stop=1 winner=0 on 5th CHECK -> game_over=1, result=0, move_count=5, 5 move_ack pulses.
REQ-028 Turn/occupancy: P1 valid while cur_player=0 -> p1_ready=0; P1 requests occupied (0,0) -> move_reject, cur_player stays 1, bitmap unchanged; P0 sends x=3 -> move_reject.
REQ-029 Timeout: TIMEOUT_CYCLES=4, no requests after start -> forfeit pulse after 4 TURN cycles, cur_player=1; reject in between does not restart count.
REQ-030 Draw: nine legal alternating moves with engine stop=0 throughout -> DONE, result=3, move_count=9; then start -> new game, cur_player=1 first.
REQ-031 Reset mid-CHECK: reset asserted during CHECK -> next cycle IDLE, eng_enable=0, result=2, bitmap=0; simultaneous start+reset -> stays IDLE.
